// File: rtl/float_class_pipe_pkg.sv
// +----------------------------------------------------------------------------+
// | Module   : float_pkg                                                       |
// | Purpose  : Shared definitions for the floating-point classifier: class     |
// |            index constants, the one-hot class type and the standard        |
// |            exponent/mantissa widths for half, single and double precision. |
// | Ports    : none (package)                                                  |
// | Revision : 1.0  initial release                                            |
// +----------------------------------------------------------------------------+
`default_nettype none

package float_pkg;

   localparam int FC_ZERO = 0;
   localparam int FC_NORM = 1;
   localparam int FC_SUB  = 2;
   localparam int FC_INF  = 3;
   localparam int FC_NAN  = 4;
   localparam int FC_NUM  = 5;

   typedef logic [FC_NUM-1:0] fclass_t;

   localparam int HALF_EXP_W   = 5;
   localparam int HALF_MAN_W   = 10;
   localparam int SINGLE_EXP_W = 8;
   localparam int SINGLE_MAN_W = 23;
   localparam int DOUBLE_EXP_W = 11;
   localparam int DOUBLE_MAN_W = 52;

   function automatic fclass_t fc_onehot(input int idx);
      return fclass_t'(1) << idx;
   endfunction

endpackage

`default_nettype wire

// File: rtl/float_class_pipe_if.sv
// +----------------------------------------------------------------------------+
// | Module   : float_class_pipe_if                                             |
// | Purpose  : Input/output valid-ready streams of the float classifier.       |
// | Ports    : in_valid/in_ready/in_num   - float word stream into the block   |
// |            out_valid/out_ready        - result stream out of the block     |
// |            out_type/out_sign/out_quiet - one-hot class, sign, quiet flag   |
// |            modport slave  : classifier view                                |
// |            modport master : producer/consumer view                         |
// | Revision : 1.0  initial release                                            |
// +----------------------------------------------------------------------------+
`default_nettype none

interface float_class_pipe_if #(
   parameter int EXP_W = 8,
   parameter int MAN_W = 23
);
   import float_pkg::*;

   logic                   in_valid;
   logic                   in_ready;
   logic [EXP_W+MAN_W:0]   in_num;
   logic                   out_valid;
   logic                   out_ready;
   fclass_t                out_type;
   logic                   out_sign;
   logic                   out_quiet;

   modport slave (
      input  in_valid, in_num, out_ready,
      output in_ready, out_valid, out_type, out_sign, out_quiet
   );

   modport master (
      output in_valid, in_num, out_ready,
      input  in_ready, out_valid, out_type, out_sign, out_quiet
   );

endinterface

`default_nettype wire

// File: rtl/float_class_pipe_decode.sv
// +----------------------------------------------------------------------------+
// | Module   : float_class_decode                                              |
// | Purpose  : Combinational IEEE-754 field decode: one-hot class, sign and    |
// |            quiet-NaN flag of a {sign, exp, man} word.                      |
// | Ports    : num   in  1+EXP_W+MAN_W  float word                             |
// |            cls   out 5              one-hot class                          |
// |            sign  out 1              sign bit                               |
// |            quiet out 1              mantissa MSB for NaN, else 0           |
// | Revision : 1.0  initial release                                            |
// +----------------------------------------------------------------------------+
`default_nettype none

module float_class_decode
   import float_pkg::*;
#(
   parameter int EXP_W = 8,
   parameter int MAN_W = 23
) (
   input  logic [EXP_W+MAN_W:0] num,
   output fclass_t              cls,
   output logic                 sign,
   output logic                 quiet
);

   logic [EXP_W-1:0] exp_f;
   logic [MAN_W-1:0] man_f;
   logic             exp_zero;
   logic             exp_ones;
   logic             man_zero;

   assign sign     = num[EXP_W+MAN_W];
   assign exp_f    = num[MAN_W +: EXP_W];
   assign man_f    = num[MAN_W-1:0];
   assign exp_zero = (exp_f == '0);
   assign exp_ones = &exp_f;
   assign man_zero = (man_f == '0);

   always_comb begin
      cls   = '0;
      quiet = 1'b0;
      if (exp_zero) begin
         cls = man_zero ? fc_onehot(FC_ZERO) : fc_onehot(FC_SUB);
      end else if (exp_ones) begin
         cls   = man_zero ? fc_onehot(FC_INF) : fc_onehot(FC_NAN);
         quiet = !man_zero && man_f[MAN_W-1];
      end else begin
         cls = fc_onehot(FC_NORM);
      end
   end

endmodule

`default_nettype wire

// File: rtl/float_class_pipe.sv
// +----------------------------------------------------------------------------+
// | Module   : float_class_pipe                                                |
// | Purpose  : Two-stage pipelined IEEE-754 classifier with valid/ready flow   |
// |            control and optional saturating per-class event counters.      |
// |            Build option: define FLOAT_CLASS_CNT_EN to build the counters;  |
// |            otherwise cnt_* are tied to 0 and cnt_clr is ignored.           |
// | Ports    : clk, rst_n (async, active low)                                  |
// |            bus      float_class_pipe_if.slave  input/result streams        |
// |            cnt_clr  synchronous clear of all counters                      |
// |            cnt_zero/norm/sub/inf/nan  per-class transfer counts            |
// | Revision : 1.0  initial release                                            |
// +----------------------------------------------------------------------------+
`default_nettype none

module float_class_pipe
   import float_pkg::*;
#(
   parameter int EXP_W = SINGLE_EXP_W,
   parameter int MAN_W = SINGLE_MAN_W,
   parameter int CNT_W = 16
) (
   input  logic                 clk,
   input  logic                 rst_n,
   float_class_pipe_if.slave    bus,
   input  logic                 cnt_clr,
   output logic [CNT_W-1:0]     cnt_zero,
   output logic [CNT_W-1:0]     cnt_norm,
   output logic [CNT_W-1:0]     cnt_sub,
   output logic [CNT_W-1:0]     cnt_inf,
   output logic [CNT_W-1:0]     cnt_nan
);

   localparam int WORD_W = 1 + EXP_W + MAN_W;

   logic              s1_valid;
   logic [WORD_W-1:0] s1_num;
   logic              s2_valid;
   fclass_t           s2_type;
   logic              s2_sign;
   logic              s2_quiet;
   logic              s2_can_load;

   fclass_t           dec_type;
   logic              dec_sign;
   logic              dec_quiet;

   // out_ready reaches in_ready combinationally so a full, stalled pipe
   // reopens in the same cycle the consumer accepts.
   assign s2_can_load  = !s2_valid || bus.out_ready;
   assign bus.in_ready = !s1_valid || s2_can_load;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s1_valid <= 1'b0;
         s1_num   <= '0;
      end else if (bus.in_ready) begin
         s1_valid <= bus.in_valid;
         if (bus.in_valid) begin
            s1_num <= bus.in_num;
         end
      end
   end

   float_class_decode #(
      .EXP_W (EXP_W),
      .MAN_W (MAN_W)
   ) u_decode (
      .num   (s1_num),
      .cls   (dec_type),
      .sign  (dec_sign),
      .quiet (dec_quiet)
   );

   // Result fields only change when a new word lands, keeping them stable
   // through a consumer stall.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s2_valid <= 1'b0;
         s2_type  <= '0;
         s2_sign  <= 1'b0;
         s2_quiet <= 1'b0;
      end else if (s2_can_load) begin
         s2_valid <= s1_valid;
         if (s1_valid) begin
            s2_type  <= dec_type;
            s2_sign  <= dec_sign;
            s2_quiet <= dec_quiet;
         end
      end
   end

   assign bus.out_valid = s2_valid;
   assign bus.out_type  = s2_type;
   assign bus.out_sign  = s2_sign;
   assign bus.out_quiet = s2_quiet;

`ifdef FLOAT_CLASS_CNT_EN
   logic                      xfer;
   logic [FC_NUM*CNT_W-1:0]   cnt_flat;

   assign xfer = s2_valid && bus.out_ready;

   for (genvar k = 0; k < FC_NUM; k++) begin : g_cnt
      logic [CNT_W-1:0] count;

      // Clear takes priority over a coincident transfer; counts stick at max.
      always_ff @(posedge clk or negedge rst_n) begin
         if (!rst_n) begin
            count <= '0;
         end else if (cnt_clr) begin
            count <= '0;
         end else if (xfer && s2_type[k] && (count != {CNT_W{1'b1}})) begin
            count <= count + 1'b1;
         end
      end

      assign cnt_flat[k*CNT_W +: CNT_W] = count;
   end

   assign cnt_zero = cnt_flat[FC_ZERO*CNT_W +: CNT_W];
   assign cnt_norm = cnt_flat[FC_NORM*CNT_W +: CNT_W];
   assign cnt_sub  = cnt_flat[FC_SUB*CNT_W  +: CNT_W];
   assign cnt_inf  = cnt_flat[FC_INF*CNT_W  +: CNT_W];
   assign cnt_nan  = cnt_flat[FC_NAN*CNT_W  +: CNT_W];
`else
   logic unused_cnt_clr;

   assign unused_cnt_clr = cnt_clr;
   assign cnt_zero = '0;
   assign cnt_norm = '0;
   assign cnt_sub  = '0;
   assign cnt_inf  = '0;
   assign cnt_nan  = '0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_float_class_pipe.sv
// +----------------------------------------------------------------------------+
// | Module   : tb_float_class_pipe                                             |
// | Purpose  : Scoreboard bench for float_class_pipe. Drives a single-         |
// |            precision instance (CNT_W=16) and a half-precision instance     |
// |            (CNT_W=2) with directed and random words; a reference           |
// |            classifier predicts each result, in_ready and the counters.     |
// |            Counter expectations follow FLOAT_CLASS_CNT_EN.                 |
// | Revision : 1.0  initial release                                            |
// +----------------------------------------------------------------------------+
`default_nettype none

module tb_float_class_pipe;
   import float_pkg::*;

   localparam int SE = 8;
   localparam int SM = 23;
   localparam int HE = 5;
   localparam int HM = 10;
   localparam int S_CNT_W = 16;
   localparam int H_CNT_W = 2;
`ifdef FLOAT_CLASS_CNT_EN
   localparam bit CNT_EN = 1'b1;
`else
   localparam bit CNT_EN = 1'b0;
`endif

   typedef struct {
      logic [4:0] t;
      logic       s;
      logic       q;
      int         idx;
      int         cyc;
   } exp_t;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   logic s_cnt_clr, h_cnt_clr;
   logic [4:0][S_CNT_W-1:0] s_cnt;
   logic [4:0][H_CNT_W-1:0] h_cnt;

   exp_t q_s[$];
   exp_t q_h[$];
   int   s_mc[5];
   int   h_mc[5];
   int   n_cmp = 0;
   int   n_fail = 0;
   int   cyc = 0;
   int   ready_mode = 0;
   bit   s_xfer, h_xfer;
   int   s_xi, h_xi;

   always #5 clk = ~clk;
   always @(posedge clk) cyc++;

   float_class_pipe_if #(.EXP_W(SE), .MAN_W(SM)) s_if();
   float_class_pipe_if #(.EXP_W(HE), .MAN_W(HM)) h_if();

   float_class_pipe #(.EXP_W(SE), .MAN_W(SM), .CNT_W(S_CNT_W)) u_dut_s (
      .clk(clk), .rst_n(rst_n), .bus(s_if), .cnt_clr(s_cnt_clr),
      .cnt_zero(s_cnt[FC_ZERO]), .cnt_norm(s_cnt[FC_NORM]), .cnt_sub(s_cnt[FC_SUB]),
      .cnt_inf(s_cnt[FC_INF]), .cnt_nan(s_cnt[FC_NAN])
   );

   float_class_pipe #(.EXP_W(HE), .MAN_W(HM), .CNT_W(H_CNT_W)) u_dut_h (
      .clk(clk), .rst_n(rst_n), .bus(h_if), .cnt_clr(h_cnt_clr),
      .cnt_zero(h_cnt[FC_ZERO]), .cnt_norm(h_cnt[FC_NORM]), .cnt_sub(h_cnt[FC_SUB]),
      .cnt_inf(h_cnt[FC_INF]), .cnt_nan(h_cnt[FC_NAN])
   );

   task automatic cmp(input string nm, input logic [63:0] act, input logic [63:0] expv);
      n_cmp++;
      if (act !== expv) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at t=%0t", nm, act, expv, $time);
      end
   endtask

   // Reference classifier from the IEEE-754 field rules.
   function automatic exp_t ref_class(input logic [63:0] w, input int ew, input int mw);
      exp_t r;
      logic [63:0] man, ex, emax;
      man  = w & ((64'd1 << mw) - 64'd1);
      ex   = (w >> mw) & ((64'd1 << ew) - 64'd1);
      emax = (64'd1 << ew) - 64'd1;
      r.s  = w[ew+mw];
      r.q  = 1'b0;
      r.cyc = 0;
      if (ex == 0)         r.idx = (man == 0) ? FC_ZERO : FC_SUB;
      else if (ex == emax) begin
         if (man == 0) r.idx = FC_INF;
         else begin
            r.idx = FC_NAN;
            r.q   = man[mw-1];
         end
      end else             r.idx = FC_NORM;
      r.t = 5'b00001 << r.idx;
      return r;
   endfunction

   function automatic logic [63:0] rand_word(input int ew, input int mw);
      logic [63:0] mmask, emax, man, ex;
      int kind;
      mmask = (64'd1 << mw) - 64'd1;
      emax  = (64'd1 << ew) - 64'd1;
      kind  = $urandom_range(0, 5);
      man   = {$urandom, $urandom} & mmask;
      if (man == 0) man = 64'd1;
      case (kind)
         0:       begin ex = 64'd0; man = 64'd0; end
         1:       ex = 64'd0;
         2:       begin ex = emax; man = 64'd0; end
         3:       ex = emax;
         default: ex = 64'($urandom_range(1, 32'(emax - 64'd1)));
      endcase
      return (64'($urandom_range(0, 1)) << (ew + mw)) | (ex << mw) | man;
   endfunction

   // out_ready is updated at posedge+2 so mode changes made at posedge+1 apply.
   always @(posedge clk) begin
      #2;
      case (ready_mode)
         1:       s_if.out_ready = ($urandom_range(0, 3) != 0);
         2:       s_if.out_ready = 1'b0;
         default: s_if.out_ready = 1'b1;
      endcase
      h_if.out_ready = s_if.out_ready;
   end

   // Single-precision monitor / scoreboard.
   always @(negedge clk) begin
      if (!rst_n) begin
         q_s.delete();
         s_mc = '{default: 0};
      end else begin
         cmp("s_in_ready", 64'(s_if.in_ready), 64'((q_s.size() < 2) || s_if.out_ready));
         cmp("s_out_valid", 64'(s_if.out_valid),
             64'((q_s.size() > 0) && ((cyc - q_s[0].cyc) >= 2)));
         s_xfer = 1'b0;
         if (s_if.out_valid && q_s.size() > 0) begin
            cmp("s_out_type", 64'(s_if.out_type), 64'(q_s[0].t));
            cmp("s_out_sign", 64'(s_if.out_sign), 64'(q_s[0].s));
            cmp("s_out_quiet", 64'(s_if.out_quiet), 64'(q_s[0].q));
            if (s_if.out_ready) begin
               s_xfer = 1'b1;
               s_xi   = q_s[0].idx;
               void'(q_s.pop_front());
            end
         end
         for (int k = 0; k < 5; k++) cmp($sformatf("s_cnt%0d", k), 64'(s_cnt[k]), 64'(s_mc[k]));
         if (s_cnt_clr) s_mc = '{default: 0};
         else if (CNT_EN && s_xfer && s_mc[s_xi] < (1 << S_CNT_W) - 1) s_mc[s_xi]++;
         if (s_if.in_valid && s_if.in_ready) begin
            exp_t e;
            e = ref_class(64'(s_if.in_num), SE, SM);
            e.cyc = cyc;
            q_s.push_back(e);
         end
      end
   end

   // Half-precision monitor / scoreboard.
   always @(negedge clk) begin
      if (!rst_n) begin
         q_h.delete();
         h_mc = '{default: 0};
      end else begin
         cmp("h_in_ready", 64'(h_if.in_ready), 64'((q_h.size() < 2) || h_if.out_ready));
         cmp("h_out_valid", 64'(h_if.out_valid),
             64'((q_h.size() > 0) && ((cyc - q_h[0].cyc) >= 2)));
         h_xfer = 1'b0;
         if (h_if.out_valid && q_h.size() > 0) begin
            cmp("h_out_type", 64'(h_if.out_type), 64'(q_h[0].t));
            cmp("h_out_sign", 64'(h_if.out_sign), 64'(q_h[0].s));
            cmp("h_out_quiet", 64'(h_if.out_quiet), 64'(q_h[0].q));
            if (h_if.out_ready) begin
               h_xfer = 1'b1;
               h_xi   = q_h[0].idx;
               void'(q_h.pop_front());
            end
         end
         for (int k = 0; k < 5; k++) cmp($sformatf("h_cnt%0d", k), 64'(h_cnt[k]), 64'(h_mc[k]));
         if (h_cnt_clr) h_mc = '{default: 0};
         else if (CNT_EN && h_xfer && h_mc[h_xi] < (1 << H_CNT_W) - 1) h_mc[h_xi]++;
         if (h_if.in_valid && h_if.in_ready) begin
            exp_t e;
            e = ref_class(64'(h_if.in_num), HE, HM);
            e.cyc = cyc;
            q_h.push_back(e);
         end
      end
   end

   task automatic idle(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic send_s(input logic [31:0] w);
      bit acc = 1'b0;
      s_if.in_valid = 1'b1;
      s_if.in_num   = w;
      for (int i = 0; i < 100 && !acc; i++) begin
         @(negedge clk);
         acc = s_if.in_ready;
         @(posedge clk);
         #1;
      end
      s_if.in_valid = 1'b0;
      cmp("s_accept", 64'(acc), 64'd1);
   endtask

   task automatic send_h(input logic [15:0] w);
      bit acc = 1'b0;
      h_if.in_valid = 1'b1;
      h_if.in_num   = w;
      for (int i = 0; i < 100 && !acc; i++) begin
         @(negedge clk);
         acc = h_if.in_ready;
         @(posedge clk);
         #1;
      end
      h_if.in_valid = 1'b0;
      cmp("h_accept", 64'(acc), 64'd1);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish at t=%0t", $time);
      $fatal(1, "watchdog");
   end

   initial begin
      logic [31:0] dir_s [8];
      logic [15:0] dir_h [5];
      dir_s = '{32'h0000_0000, 32'h3F80_0000, 32'h8000_0001, 32'h7F80_0000,
                32'h7FC0_0000, 32'h7F80_0001, 32'h8000_0000, 32'hFF80_0000};
      dir_h = '{16'h7C00, 16'h7E00, 16'h0001, 16'h3C00, 16'h8000};

      s_if.in_valid = 1'b0; s_if.in_num = '0; s_if.out_ready = 1'b1;
      h_if.in_valid = 1'b0; h_if.in_num = '0; h_if.out_ready = 1'b1;
      s_cnt_clr = 1'b0; h_cnt_clr = 1'b0;

      // Reset state
      repeat (3) @(posedge clk);
      #1;
      cmp("rst_out_valid", 64'(s_if.out_valid), 64'd0);
      cmp("rst_out_type", 64'(s_if.out_type), 64'd0);
      cmp("rst_out_sign", 64'(s_if.out_sign), 64'd0);
      cmp("rst_out_quiet", 64'(s_if.out_quiet), 64'd0);
      cmp("rst_in_ready", 64'(s_if.in_ready), 64'd1);
      cmp("rst_h_out_valid", 64'(h_if.out_valid), 64'd0);
      for (int k = 0; k < 5; k++) cmp($sformatf("rst_cnt%0d", k), 64'(s_cnt[k]), 64'd0);
      rst_n = 1'b1;
      idle(1);

      // Directed words, one at a time
      foreach (dir_s[i]) begin
         send_s(dir_s[i]);
         idle(3);
      end
      foreach (dir_h[i]) begin
         send_h(dir_h[i]);
         idle(3);
      end

      // Back-to-back burst with a 3-cycle consumer stall in the middle
      fork
         begin
            for (int i = 0; i < 8; i++) send_s(32'(rand_word(SE, SM)));
         end
         begin
            idle(3);
            ready_mode = 2;
            idle(3);
            ready_mode = 0;
         end
      join
      idle(5);

      // Counter saturation at CNT_W=2, then clear coinciding with a transfer
      for (int i = 0; i < 5; i++) send_h(16'h7E00);
      idle(4);
      cmp("h_cnt_nan_sat", 64'(h_cnt[FC_NAN]), CNT_EN ? 64'd3 : 64'd0);
      send_h(16'h7E01);
      h_cnt_clr = 1'b1;
      idle(2);
      h_cnt_clr = 1'b0;
      idle(2);
      cmp("h_cnt_nan_clr", 64'(h_cnt[FC_NAN]), 64'd0);

      // Randomized traffic with random backpressure and sporadic clears
      ready_mode = 1;
      fork
         begin
            for (int i = 0; i < 250; i++) begin
               send_s(32'(rand_word(SE, SM)));
               idle($urandom_range(0, 2));
            end
         end
         begin
            for (int i = 0; i < 150; i++) begin
               send_h(16'(rand_word(HE, HM)));
               idle($urandom_range(0, 3));
            end
         end
         begin
            for (int i = 0; i < 300; i++) begin
               s_cnt_clr = ($urandom_range(0, 31) == 0);
               h_cnt_clr = ($urandom_range(0, 31) == 0);
               idle(1);
            end
            s_cnt_clr = 1'b0;
            h_cnt_clr = 1'b0;
         end
      join
      ready_mode = 0;
      for (int i = 0; i < 200 && (q_s.size() != 0 || q_h.size() != 0); i++) @(posedge clk);
      #1;
      cmp("drain", 64'(q_s.size() + q_h.size()), 64'd0);

      // Reset with two words in flight
      send_s(32'h3F80_0000);
      send_s(32'h7FC0_0000);
      #1;
      rst_n = 1'b0;
      #1;
      cmp("midrst_out_valid", 64'(s_if.out_valid), 64'd0);
      for (int k = 0; k < 5; k++) cmp($sformatf("midrst_cnt%0d", k), 64'(s_cnt[k]), 64'd0);
      @(posedge clk);
      #3;
      rst_n = 1'b1;
      idle(8);
      cmp("midrst_in_ready", 64'(s_if.in_ready), 64'd1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule

`default_nettype wire
